// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the byte-serial data-memory sequencer.
//   - size codes as decoded by the memory stage (one-hot byte/half/word)
//   - FSM state encoding
//   - size_to_count(): number of byte transfers for a size code; any
//     unrecognised code is treated as a word.
package dmem_pkg;

    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [2:0] size_to_count(input logic [2:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_seq_ctrl_load_extend.sv
// load_extend: combinational sign/zero extension of an assembled load.
// Ports:
//   asm_data    in  32  little-endian assembled bytes (byte 0 in [7:0])
//   size        in  3   size code; anything other than byte/half = word
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   rdata       out 32  extended result
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] asm_data,
    input  logic [2:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    always_comb begin
        case (size)
            SIZE_B:  rdata = {{24{~is_unsigned & asm_data[7]}},  asm_data[7:0]};
            SIZE_H:  rdata = {{16{~is_unsigned & asm_data[15]}}, asm_data[15:0]};
            default: rdata = asm_data;
        endcase
    end

endmodule

// File: rtl/dmem_seq_ctrl.sv
// dmem_seq_ctrl: sequences a memory-stage load/store onto a byte-wide
// data-memory port, one byte per mem_req/mem_ack handshake, little-endian.
// The pipeline is stalled until the access completes; loads return
// assembled, extended data with a one-cycle rdata_valid pulse.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/write/size/unsigned request from the memory stage
//   req_addr, req_wdata           byte address, store data (low bytes used)
//   stall                         holds the pipeline while busy
//   rdata, rdata_valid            load result, completion pulse (ld & st)
//   mem_req/we/addr/wdata         byte transfer request to the memory
//   mem_rdata, mem_ack            byte read data, transfer complete
//   misalign_err                  misaligned-access error pulse
//
// Build option: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses are trapped (no memory traffic, misalign_err pulses in DONE).
// When undefined they are performed byte-serially and misalign_err is 0.
module dmem_seq_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack,
    output logic                  misalign_err
);

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            last_q, last_d;     // index of the final byte (n-1)
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  misalign_err_q, misalign_err_d;

    // Assembly with the byte arriving this cycle merged in, so the final
    // byte is included in the extended result registered on completion.
    logic [DATA_WIDTH-1:0] asm_nxt;
    logic [DATA_WIDTH-1:0] ext_data;

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[8*idx_q +: 8] = mem_rdata;
    end

    load_extend u_load_extend (
        .asm_data    (asm_nxt),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (ext_data)
    );

    always_comb begin
        logic [2:0] cnt;
        logic       mis;
        state_d        = state_q;
        idx_d          = idx_q;
        last_d         = last_q;
        write_d        = write_q;
        size_d         = size_q;
        uns_d          = uns_q;
        base_d         = base_q;
        wdata_d        = wdata_q;
        asm_d          = asm_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rdata_d        = rdata_q;
        rdata_valid_d  = 1'b0;
        misalign_err_d = 1'b0;
        cnt            = size_to_count(req_size);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (cnt == 3'd2 && req_addr[0]) || (cnt == 3'd4 && req_addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    last_d  = 2'(cnt - 3'd1);
                    idx_d   = 2'd0;
                    asm_d   = '0;
                    if (mis) begin
                        // Trapped: skip the memory entirely, rdata untouched.
                        state_d        = DONE;
                        rdata_valid_d  = 1'b1;
                        misalign_err_d = 1'b1;
                    end else begin
                        state_d     = XFER;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata[7:0];
                    end
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (!write_q) asm_d = asm_nxt;
                    if (idx_q == last_q) begin
                        state_d       = DONE;
                        mem_req_d     = 1'b0;
                        mem_we_d      = 1'b0;
                        rdata_valid_d = 1'b1;
                        if (!write_q) rdata_d = ext_data;
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        mem_addr_d  = base_q + ADDR_WIDTH'(idx_d);
                        mem_wdata_d = wdata_q[8*idx_d +: 8];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            last_q         <= '0;
            write_q        <= 1'b0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            base_q         <= '0;
            wdata_q        <= '0;
            asm_q          <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            write_q        <= write_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            base_q         <= base_d;
            wdata_q        <= wdata_d;
            asm_q          <= asm_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Stall asserts in the accepting IDLE cycle; gated by rst_n so it drops
    // the moment reset is applied.
    assign stall        = rst_n & ((state_q == XFER) | ((state_q == IDLE) & req_valid));
    assign rdata        = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: doc/dmem_seq_ctrl.md
Name: dmem_seq_ctrl

Overview:
- Sequences each load/store from the memory stage onto a byte-wide external data-memory port.
- Performs one byte transfer per mem_req/mem_ack handshake, little-endian.
- Stalls the pipeline until the access completes, then returns assembled, extended load data.
- Sits between the memory-stage control (size/sign from decode: 001 byte, 010 half, 100 word) and the data-memory macro.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- DATA_WIDTH, 32, register data width; fixed at 32 (4 bytes max).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- req_valid  input  1  memory-stage access request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  3  001 byte, 010 half, 100 word; any other code = word.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data; low bytes used.
- stall  output  1  holds the pipeline while an access is pending.
- rdata  output  32  extended load result.
- rdata_valid  output  1  one-cycle completion pulse (loads and stores).
- mem_req  output  1  byte transfer request.
- mem_we  output  1  byte write enable.
- mem_addr  output  ADDR_WIDTH  byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte, valid with mem_ack.
- mem_ack  input  1  transfer complete.
- misalign_err  output  1  error pulse (see Optional Feature).

Behaviour:
- Reset (async, rst_n low): state IDLE, byte index 0, captured request cleared.
  - Outputs: stall 0, rdata 0, rdata_valid 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, misalign_err 0.
  - Reset mid-transfer abandons the access; mem_req drops immediately. No retry after release.
- FSM states: IDLE, XFER, DONE.
  - IDLE: when req_valid=1, capture write/size/unsigned/addr/wdata, set n (1/2/4), clear index and assembly register, go XFER. stall is combinationally 1 in that same cycle.
  - XFER: stall=1, mem_req=1, mem_addr=base+idx (wraps modulo 2^ADDR_WIDTH), mem_we=captured write, mem_wdata=wdata byte idx. Outputs are registered and stay stable until mem_ack.
    - On mem_ack with a load: store mem_rdata into assembly byte idx.
    - If idx=n-1, go DONE; otherwise idx++.
  - DONE: stall=0, mem_req=0, rdata_valid=1.
    - Load: rdata = assembled value, sign- or zero-extended from bit 8n-1.
    - Store: rdata unchanged.
    - Next state is always IDLE; req_valid is ignored in DONE.
- mem_ack is ignored whenever mem_req=0.
- Latency with mem_ack tied high: byte access has 1 XFER cycle, half 2, word 4, followed by one DONE cycle.
- rdata holds its value until the next load completes.
- Misaligned accesses are legal by default: bytes transfer sequentially across word boundaries.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]≠0, or a word access with addr[1:0]≠0, goes IDLE→DONE with no mem_req. In DONE, misalign_err=1, rdata_valid=1, rdata unchanged.
- Undefined: misalign_err is tied 0 and misaligned accesses are performed byte-serially.

Decomposition:
- Package dmem_pkg holds:
  - size codes SIZE_B=3'b001, SIZE_H=3'b010, SIZE_W=3'b100;
  - FSM state enum (IDLE, XFER, DONE);
  - function size_to_count(size) returning 1/2/4, with word as the default.
- One sub-module: load_extend. It is combinational; it takes the 32-bit assembly, the size code and the unsigned flag, and produces rdata.

Test Plan:
- Word load, addr 0x100, memory bytes 0x78,0x56,0x34,0x12, mem_ack tied high → mem_addr steps 0x100..0x103, stall high for 5 cycles, rdata=0x12345678 with rdata_valid in cycle 6.
- Signed byte load of 0x80 → rdata=0xFFFFFF80. Unsigned half load of bytes 0x01,0x80 → rdata=0x00008001.
- Store half, wdata 0xAABBCCDD, addr 0x20, mem_ack delayed 3 cycles per byte → writes 0xDD@0x20 then 0xCC@0x21, each held stable until ack; mem_we=1; rdata unchanged.
- Back-to-back: req_valid held high across two word loads → IDLE→XFER→DONE→IDLE→XFER, second access accepted in the IDLE cycle after DONE; no byte skipped.
- rst_n asserted during the 2nd byte of a word store → mem_req and stall drop asynchronously; after release state is IDLE and no further memory traffic occurs.
- With DMEM_MISALIGN_TRAP_EN, word load at 0x102 → no mem_req, misalign_err=1 and rdata_valid=1 in the second cycle. Without the macro, the same access reads 0x102..0x105.
